// File: rtl/truth_table_checker_if.sv
// Bus between the truth-table checker and its environment:
// start/func_in into the checker, sweep vector and results out.
interface truth_table_checker_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic            func_in;
    logic [N_IN-1:0] vec_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err_idx;
    logic            err_valid;

    modport master (
        output start,
        output func_in,
        input  vec_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_err_idx,
        input  err_valid
    );

    modport slave (
        input  start,
        input  func_in,
        output vec_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_err_idx,
        output err_valid
    );
endinterface

// File: rtl/truth_table_checker.sv
// Sweeps every input vector into a combinational block, samples its
// output after a settle delay and scores it against a truth table.
module truth_table_checker #(
    parameter int                   N_IN     = 2,
    parameter logic [2**N_IN-1:0]   EXPECTED = 4'b1011,
    parameter int                   SETTLE   = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_checker_if.slave bus
);
    localparam int              NV          = 1 << N_IN;
    localparam logic [N_IN:0]   ERR_MAX     = NV[N_IN:0];
    localparam logic [N_IN-1:0] LAST_VEC    = '1;
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t          state_q, state_n;
    logic [N_IN-1:0] vec_q, vec_n;
    logic [3:0]      cnt_q, cnt_n;
    logic [N_IN:0]   err_q, err_n;
    logic [N_IN-1:0] idx_q, idx_n;
    logic            ev_q, ev_n;
    logic            pass_q, pass_n;
    logic            busy_q, busy_n;
    logic            done_q, done_n;
    logic            mism;
    logic [N_IN:0]   err_inc;

    // State and result registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            idx_q   <= '0;
            ev_q    <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            vec_q   <= vec_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
            idx_q   <= idx_n;
            ev_q    <= ev_n;
            pass_q  <= pass_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Next-state: launch, settle, sample-and-score, finish
    always_comb begin
        state_n = state_q;
        vec_n   = vec_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        idx_n   = idx_q;
        ev_n    = ev_q;
        pass_n  = pass_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        mism    = 1'b0;
        err_inc = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = DRIVE;
                    vec_n   = '0;
                    cnt_n   = '0;
                    err_n   = '0;
                    idx_n   = '0;
                    ev_n    = 1'b0;
                    pass_n  = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                mism = bus.func_in != EXPECTED[vec_q];
                if (mism) begin
                    if (err_q != ERR_MAX) begin
                        err_inc = err_q + 1'b1;
                    end
                    if (!ev_q) begin
                        idx_n = vec_q;
                        ev_n  = 1'b1;
                    end
                end
                err_n = err_inc;
                if (vec_q == LAST_VEC) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    pass_n  = (err_inc == '0);
                end else begin
                    state_n = DRIVE;
                    vec_n   = vec_q + 1'b1;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.vec_out       = vec_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = idx_q;
    assign bus.err_valid     = ev_q;
endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Upstream/downstream companion to the 2-input NAND-only logic stage.
- Sequentially drives every input combination into the combinational function block and samples its output after a settle delay.
- Compares each sample against a parameterised expected truth table and reports the mismatch count, the first failing index, and pass/fail.
- Replaces ad-hoc #delay testbench sweeps with a synthesizable self-check engine.

Parameters:
N_IN, 2, number of function inputs; sweeps 2**N_IN vectors.
EXPECTED, 4'b1011, expected output per vector index (bit i = expected s for vector i; default encodes ~a | b with index {a,b}). Width is 2**N_IN.
SETTLE, 2, cycles each vector is held before sampling (1..15).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  begin sweep; honoured only in IDLE or DONE
func_in  input  1  output of function stage under test (s)
vec_out  output  N_IN  vector driven to function stage ({a,b} for N_IN=2, MSB = a)
busy  output  1  high while sweeping
done  output  1  one-cycle pulse when sweep completes
pass  output  1  valid from done until next start; 1 when err_count==0
err_count  output  N_IN+1  number of mismatching vectors in last sweep
first_err_idx  output  N_IN  index of lowest mismatching vector
err_valid  output  1  first_err_idx is meaningful (at least one mismatch)

Behaviour:
- All state changes occur on the rising clk edge. rst_n low at an edge takes priority over every other input.
- Reset values: all outputs 0, vec_out=0, state=IDLE, internal counters 0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: outputs hold. start=1 -> DRIVE, vec_out=0, settle counter=0, err_count=0, err_valid=0, first_err_idx=0, pass=0, busy=1.
- DRIVE: vec_out stable; settle counter increments each cycle. When the counter reaches SETTLE-1 -> SAMPLE.
  - Vector i is therefore held for SETTLE cycles in DRIVE plus 1 cycle in SAMPLE.
- SAMPLE: compare func_in with EXPECTED[vec_out].
  - Mismatch: err_count increments (saturates at 2**N_IN; it cannot exceed this by construction).
  - First mismatch only: capture first_err_idx=vec_out and set err_valid=1.
  - vec_out == 2**N_IN-1 -> DONE, with done=1 for exactly this transition cycle, busy=0, pass=(final err_count==0).
  - Otherwise vec_out increments, settle counter clears, -> DRIVE.
- Ordering within SAMPLE: the comparison uses the registered err_count plus the current mismatch, so pass reflects the final vector.
- DONE: results hold; vec_out holds the last vector; done=0 after the first cycle. start=1 -> restart as from IDLE, with results cleared on the same edge.
- Latency: start edge to done pulse = 2**N_IN * (SETTLE+1) + 1 cycles. Default: 4*3+1 = 13.
- start while busy is ignored; there is no restart mid-sweep.
- rst_n low mid-sweep: immediate return to IDLE with reset values; partial results are discarded.
- func_in is sampled only in SAMPLE; activity in other states has no effect.
- No wrap-around of vec_out: the sweep ends at the all-ones index.

Test Plan:
- Golden NAND stage (s = ~a|b) connected, defaults, start pulse -> vec_out steps 0,1,2,3 every 3 cycles; done pulse at cycle 13; pass=1, err_count=0, err_valid=0.
- func_in tied 1 -> mismatch only at index 2; err_count=1, first_err_idx=2, err_valid=1, pass=0.
- func_in tied 0 -> mismatches at 0,1,3; err_count=3, first_err_idx=0, pass=0.
- start re-pulsed at cycle 5 of a sweep -> ignored; done still at cycle 13. Start pulse in DONE -> results cleared on that edge and a new sweep begins.
- rst_n=0 at cycle 7 -> next edge: busy=0, vec_out=0, err_count=0, state IDLE. No done pulse appears later.
- SETTLE=1, N_IN=3, EXPECTED=8'hFF with func_in=1 -> done at cycle 8*2+1=17; pass=1, err_count=0.
